// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and game-key decoder.
// Raw ps2_clk/ps2_data are synchronized and glitch filtered, then 11-bit frames
// are deframed into scan-code bytes on filtered ps2_clk falling edges. A small
// FSM tracks the F0 (break) and E0 (extended) prefixes and maps the game keys
// W/A/S/D/space to uppercase ASCII on key_code/released.
// Build option: define PS2_ARROW_KEYS_EN to map E0 6B / E0 74 (left/right
// arrows) onto 'A' / 'D'; otherwise extended codes are consumed silently.
`timescale 1ns/1ps

module ps2_key_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 65_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [6:0] key_code,
    output logic       released,
    output logic       key_event,
    output logic       frame_err
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]   TO_RELOAD = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK
    } state_t;

    // Plain scan code -> {hit, ascii}; hit=0 for keys the game ignores.
    function automatic logic [7:0] map_std(input logic [7:0] sc);
        logic [7:0] r;
        case (sc)
            8'h1C:   r = {1'b1, 7'd65};
            8'h23:   r = {1'b1, 7'd68};
            8'h1D:   r = {1'b1, 7'd87};
            8'h1B:   r = {1'b1, 7'd83};
            8'h29:   r = {1'b1, 7'd32};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

`ifdef PS2_ARROW_KEYS_EN
    // Extended (E0-prefixed) scan code -> {hit, ascii}; arrows alias A/D.
    function automatic logic [7:0] map_ext(input logic [7:0] sc);
        logic [7:0] r;
        case (sc)
            8'h6B:   r = {1'b1, 7'd65};
            8'h74:   r = {1'b1, 7'd68};
            default: r = 8'h00;
        endcase
        return r;
    endfunction
`endif

    // Odd parity over data+parity, start low, stop high.
    function automatic logic frame_ok(input logic [10:0] f);
        return ~f[0] & (^f[9:1]) & f[10];
    endfunction

    logic              clk_s1_p0, clk_s2_p0, dat_s1_p0, dat_s2_p0;
    logic              clk_f_p1, dat_f_p1;
    logic [FCNT_W-1:0] clk_fcnt_p1, dat_fcnt_p1;
    logic              clk_f_d_p2;
    logic              fall_p2;
    logic [3:0]        bit_cnt_p2;
    logic [9:0]        shift_p2;
    logic [TO_W-1:0]   to_cnt_p2;
    logic [10:0]       frame_p2;
    logic [7:0]        byte_p3;
    logic              vld_p3;
    state_t            state, state_nxt;
    logic [6:0]        code_nxt;
    logic              rel_nxt, evt_nxt;
    logic [7:0]        std_hit;
`ifdef PS2_ARROW_KEYS_EN
    logic [7:0]        ext_hit;
`endif

    // Stage p0: two-flop synchronizers for both pad lines (idle level is high).
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_p0 <= 1'b1;
            clk_s2_p0 <= 1'b1;
            dat_s1_p0 <= 1'b1;
            dat_s2_p0 <= 1'b1;
        end else begin
            clk_s1_p0 <= ps2_clk;
            clk_s2_p0 <= clk_s1_p0;
            dat_s1_p0 <= ps2_data;
            dat_s2_p0 <= dat_s1_p0;
        end
    end

    // Stage p1: ps2_clk glitch filter, flips after FILTER_LEN differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_f_p1    <= 1'b1;
            clk_fcnt_p1 <= '0;
        end else if (clk_s2_p0 == clk_f_p1) begin
            clk_fcnt_p1 <= '0;
        end else if (clk_fcnt_p1 == FCNT_LAST) begin
            clk_f_p1    <= clk_s2_p0;
            clk_fcnt_p1 <= '0;
        end else begin
            clk_fcnt_p1 <= clk_fcnt_p1 + 1'b1;
        end
    end

    // Stage p1: ps2_data glitch filter, same rule as the clock line.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_f_p1    <= 1'b1;
            dat_fcnt_p1 <= '0;
        end else if (dat_s2_p0 == dat_f_p1) begin
            dat_fcnt_p1 <= '0;
        end else if (dat_fcnt_p1 == FCNT_LAST) begin
            dat_f_p1    <= dat_s2_p0;
            dat_fcnt_p1 <= '0;
        end else begin
            dat_fcnt_p1 <= dat_fcnt_p1 + 1'b1;
        end
    end

    // Stage p2: delayed filtered clock for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) clk_f_d_p2 <= 1'b1;
        else     clk_f_d_p2 <= clk_f_p1;
    end

    assign fall_p2  = clk_f_d_p2 & ~clk_f_p1;
    // The bit arriving now completes the frame when bit_cnt_p2 == 10.
    assign frame_p2 = {dat_f_p1, shift_p2};

    // Stage p2: bit counter, frame check and mid-frame timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_p2 <= '0;
            to_cnt_p2  <= TO_RELOAD;
            vld_p3     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            vld_p3    <= 1'b0;
            frame_err <= 1'b0;
            if (fall_p2) begin
                to_cnt_p2 <= TO_RELOAD;
                if (bit_cnt_p2 == 4'd10) begin
                    bit_cnt_p2 <= '0;
                    vld_p3     <= frame_ok(frame_p2);
                    frame_err  <= ~frame_ok(frame_p2);
                end else begin
                    bit_cnt_p2 <= bit_cnt_p2 + 4'd1;
                end
            end else if (bit_cnt_p2 != 4'd0) begin
                if (to_cnt_p2 == '0) begin
                    bit_cnt_p2 <= '0;
                    frame_err  <= 1'b1;
                    to_cnt_p2  <= TO_RELOAD;
                end else begin
                    to_cnt_p2 <= to_cnt_p2 - 1'b1;
                end
            end else begin
                to_cnt_p2 <= TO_RELOAD;
            end
        end
    end

    // Stage p2 -> p3: shift in filtered data bits and latch the completed byte.
    always_ff @(posedge clk) begin
        if (fall_p2) begin
            shift_p2 <= frame_p2[10:1];
            if (bit_cnt_p2 == 4'd10) byte_p3 <= frame_p2[8:1];
        end
    end

    assign std_hit = map_std(byte_p3);
`ifdef PS2_ARROW_KEYS_EN
    assign ext_hit = map_ext(byte_p3);
`endif

    // Decoder next-state and output values, advanced only by a valid byte.
    always_comb begin
        state_nxt = state;
        code_nxt  = key_code;
        rel_nxt   = released;
        evt_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vld_p3) begin
                    if (byte_p3 == SC_BREAK) begin
                        state_nxt = ST_BREAK;
                    end else if (byte_p3 == SC_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (std_hit[7]) begin
                        code_nxt = std_hit[6:0];
                        rel_nxt  = 1'b0;
                        evt_nxt  = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (frame_err) begin
                    state_nxt = ST_IDLE;
                end else if (vld_p3) begin
                    if (std_hit[7] && std_hit[6:0] == key_code) begin
                        rel_nxt = 1'b1;
                        evt_nxt = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
            end
            ST_EXT: begin
                if (frame_err) begin
                    state_nxt = ST_IDLE;
                end else if (vld_p3) begin
                    if (byte_p3 == SC_BREAK) begin
                        state_nxt = ST_EXT_BREAK;
                    end else begin
`ifdef PS2_ARROW_KEYS_EN
                        if (ext_hit[7]) begin
                            code_nxt = ext_hit[6:0];
                            rel_nxt  = 1'b0;
                            evt_nxt  = 1'b1;
                        end
`endif
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_EXT_BREAK: begin
                if (frame_err) begin
                    state_nxt = ST_IDLE;
                end else if (vld_p3) begin
`ifdef PS2_ARROW_KEYS_EN
                    if (ext_hit[7] && ext_hit[6:0] == key_code) begin
                        rel_nxt = 1'b1;
                        evt_nxt = 1'b1;
                    end
`endif
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p3 -> out: decoder state and registered key outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            key_code  <= 7'd0;
            released  <= 1'b1;
            key_event <= 1'b0;
        end else begin
            state     <= state_nxt;
            key_code  <= code_nxt;
            released  <= rel_nxt;
            key_event <= evt_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with
// hand-computed key_code/released/event expectations.
`timescale 1ns/1ps

module tb_ps2_key_decoder;

    localparam int TO   = 200;
    localparam int FLEN = 4;
    // Raw stop-bit fall -> key_event: 2 sync flops + FLEN filter samples,
    // then 1 cycle to byte_valid and 1 cycle to the registered outputs.
    localparam int LAT  = 2 + FLEN + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [6:0] key_code;
    logic       released;
    logic       key_event;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int ev_cnt = 0;
    int err_cnt = 0;
    int ev0;
    int er0;

    ps2_key_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_code (key_code),
        .released (released),
        .key_event(key_event),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (key_event) ev_cnt <= ev_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cycles(10);
        ps2_clk = 1'b0;
        cycles(20);
        ps2_clk = 1'b1;
        cycles(10);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        cycles(20);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0), 11);
    endtask

    task automatic snap();
        ev0 = ev_cnt;
        er0 = err_cnt;
    endtask

    initial begin
        logic [10:0] f;
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cycles(4);
        rst = 1'b0;
        cycles(2);
        chk("reset_key_code", 32'(key_code), 32'd0);
        chk("reset_released", 32'(released), 32'd1);
        chk("reset_key_event", 32'(key_event), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);

        // 1C with parity flipped: error pulse, outputs untouched.
        snap();
        send_bits(mk_frame(8'h1C, 1'b1), 11);
        chk("badpar_err_pulses", 32'(err_cnt - er0), 32'd1);
        chk("badpar_no_event", 32'(ev_cnt - ev0), 32'd0);
        chk("badpar_key_code", 32'(key_code), 32'd0);
        chk("badpar_released", 32'(released), 32'd1);

        // Next valid frame decodes.
        snap();
        send(8'h23);
        chk("d_key_code", 32'(key_code), 32'd68);
        chk("d_released", 32'(released), 32'd0);
        chk("d_events", 32'(ev_cnt - ev0), 32'd1);

        // Reset in the middle of a frame drops the partial bits.
        send_bits(mk_frame(8'h1C, 1'b0), 4);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(2);
        chk("midrst_key_code", 32'(key_code), 32'd0);
        chk("midrst_released", 32'(released), 32'd1);

        // 1C with exact output latency from the raw stop-bit fall.
        snap();
        f = mk_frame(8'h1C, 1'b0);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        cycles(10);
        ps2_clk = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat_key_event_c%0d", k), 32'(key_event), 32'(k == LAT));
        end
        cycles(20);
        ps2_clk = 1'b1;
        cycles(20);
        chk("a_key_code", 32'(key_code), 32'd65);
        chk("a_released", 32'(released), 32'd0);
        chk("a_events", 32'(ev_cnt - ev0), 32'd1);

        // F0 1C releases A.
        snap();
        send(8'hF0);
        send(8'h1C);
        chk("a_brk_released", 32'(released), 32'd1);
        chk("a_brk_key_code", 32'(key_code), 32'd65);
        chk("a_brk_events", 32'(ev_cnt - ev0), 32'd1);

        // 1C, 23, F0 1C: second key overwrites, stale break ignored.
        send(8'h1C);
        snap();
        send(8'h23);
        send(8'hF0);
        send(8'h1C);
        chk("over_key_code", 32'(key_code), 32'd68);
        chk("over_released", 32'(released), 32'd0);
        chk("over_events", 32'(ev_cnt - ev0), 32'd1);
        send(8'hF0);
        send(8'h23);
        chk("over_brk_released", 32'(released), 32'd1);
        chk("over_brk_events", 32'(ev_cnt - ev0), 32'd2);

        // Clocking stalls after 5 bits: timeout error, then clean frame.
        snap();
        send_bits(mk_frame(8'h23, 1'b0), 5);
        cycles(TO + 100);
        chk("timeout_err", 32'(err_cnt - er0), 32'd1);
        send(8'h23);
        chk("post_to_key_code", 32'(key_code), 32'd68);
        chk("post_to_released", 32'(released), 32'd0);
        chk("post_to_err", 32'(err_cnt - er0), 32'd1);

        // Short glitch on ps2_clk is filtered out.
        snap();
        ps2_clk = 1'b0;
        cycles(2);
        ps2_clk = 1'b1;
        cycles(TO + 100);
        chk("glitch_no_err", 32'(err_cnt - er0), 32'd0);
        send(8'h1B);
        chk("s_key_code", 32'(key_code), 32'd83);
        chk("s_released", 32'(released), 32'd0);

        send(8'h29);
        chk("space_key_code", 32'(key_code), 32'd32);
        send(8'h1D);
        chk("w_key_code", 32'(key_code), 32'd87);

        // Extended left arrow make and break.
        snap();
        send(8'hE0);
        send(8'h6B);
`ifdef PS2_ARROW_KEYS_EN
        chk("ext_make_key_code", 32'(key_code), 32'd65);
        chk("ext_make_released", 32'(released), 32'd0);
        chk("ext_make_events", 32'(ev_cnt - ev0), 32'd1);
`else
        chk("ext_make_key_code", 32'(key_code), 32'd87);
        chk("ext_make_events", 32'(ev_cnt - ev0), 32'd0);
`endif
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
`ifdef PS2_ARROW_KEYS_EN
        chk("ext_brk_released", 32'(released), 32'd1);
        chk("ext_brk_events", 32'(ev_cnt - ev0), 32'd2);
`else
        chk("ext_brk_released", 32'(released), 32'd0);
        chk("ext_brk_events", 32'(ev_cnt - ev0), 32'd0);
`endif
        send(8'h1B);
        chk("post_ext_key_code", 32'(key_code), 32'd83);
        chk("post_ext_released", 32'(released), 32'd0);

        // Frame error after F0 returns the decoder to idle: 1B is a make.
        snap();
        send(8'hF0);
        send_bits(mk_frame(8'h1B, 1'b1), 11);
        send(8'h1B);
        chk("err_idle_err", 32'(err_cnt - er0), 32'd1);
        chk("err_idle_released", 32'(released), 32'd0);
        chk("err_idle_key_code", 32'(key_code), 32'd83);
        chk("err_idle_events", 32'(ev_cnt - ev0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives raw PS/2 keyboard clock/data lines and deframes 11-bit frames into scan-code bytes.
- Tracks make, break (F0) and extended (E0) prefixes and converts a small set of game keys to 7-bit ASCII.
- Drives key_code/released directly into the player movement stage, one per player.

Parameters:
FILTER_LEN, 4, consecutive equal synchronized samples required before the filtered ps2_clk/ps2_data level changes
TIMEOUT_CYCLES, 65_000, clk cycles without a filtered ps2_clk falling edge mid-frame before the frame is aborted

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
ps2_clk  in  1  raw PS/2 clock from pad, asynchronous
ps2_data  in  1  raw PS/2 data from pad, asynchronous
key_code  out  7  ASCII of last accepted mapped key
released  out  1  1 = last accepted key released / no key held
key_event  out  1  one-cycle pulse whenever key_code or released is written
frame_err  out  1  one-cycle pulse on parity, start or stop error, or timeout

Behaviour:
- Reset values: key_code=0, released=1, key_event=0, frame_err=0; bit counter=0; decoder in ST_IDLE; filter outputs=1.
- Input path: 2-FF synchronizer per line, then a glitch filter. The filtered level flips only after FILTER_LEN equal samples differ from it.
- Falling-edge detect on filtered clk. Filtered data is sampled on that edge.
- Frame format: start=0, 8 data bits LSB-first, odd parity, stop=1. Bit counter runs 0..10.
- On the 11th edge:
  - if start==0, parity odd and stop==1, byte_valid pulses next cycle;
  - otherwise frame_err pulses next cycle and the byte is dropped.
  - In both cases the counter returns to 0.
- Timeout: while counter!=0, a down-counter reloads on every edge. On reaching 0 it clears the counter and pulses frame_err. Idle with counter==0 never times out.
- Decoder FSM, advanced only on byte_valid:
  - ST_IDLE: F0 -> ST_BREAK; E0 -> ST_EXT; mapped make -> key_code=ascii, released=0, key_event=1; others ignored.
  - ST_BREAK: mapped code equal to current key_code -> released=1, key_event=1. Otherwise no output change. Always return to ST_IDLE.
  - ST_EXT: F0 -> ST_EXT_BREAK; any other byte -> extended make, then ST_IDLE.
  - ST_EXT_BREAK: extended break, then ST_IDLE.
- Mapping (scan -> ASCII): 1C->65 'A', 23->68 'D', 1D->87 'W', 1B->83 'S', 29->32 space. Outputs are uppercase only.
- Typematic repeat of the held make rewrites the same values and pulses key_event again. This is harmless to the downstream stage.
- A make of a second key while one is held overwrites key_code. A break of the first key afterwards is ignored, because it does not match key_code.
- Latency: outputs and key_event update exactly 2 clk cycles after the filtered falling edge of the stop bit. That is 1 cycle for byte_valid, then 1 cycle for the registered outputs.
- frame_err while the decoder is in ST_BREAK, ST_EXT or ST_EXT_BREAK forces the decoder to ST_IDLE.
- Synchronous reset mid-frame discards the partial byte and forces every reset value on the next edge.

Optional Feature:
- Macro: PS2_ARROW_KEYS_EN.
- Defined: extended make/break of E0 6B (left arrow) behaves as 'A' (65), and E0 74 (right arrow) behaves as 'D' (68). Release matching is the same as for plain keys.
- Undefined: every extended make/break is consumed with no output change and no key_event.

Test Plan:
- Frame 1C, valid parity -> key_code=65, released=0, key_event high for 1 cycle, exactly 2 clk after the stop-bit edge.
- Frames 1C, F0, 1C -> released=1 after the third frame; key_code stays 65; 2 key_event pulses total.
- Frames 1C, 23, F0, 1C -> key_code=68, released=0 (mismatched break ignored). Then F0, 23 -> released=1.
- Frame 1C with parity bit flipped -> frame_err pulse; key_code=0, released=1 unchanged. Next valid 23 -> key_code=68.
- Stop clocking after 5 bits for TIMEOUT_CYCLES -> frame_err pulse. The following full frame 23 decodes correctly. A 2-cycle glitch on ps2_clk (shorter than FILTER_LEN) -> no bit captured.
- E0 6B: with PS2_ARROW_KEYS_EN -> key_code=65, released=0, then E0 F0 6B -> released=1. Without the macro -> no key_event for either.
